// File: rtl/mem_access_unit_if.sv
// Pipeline-side and data-memory-side signals of the load/store unit.
// The unit itself is the bus master; the surrounding pipeline/memory model is the slave view.
interface mem_access_unit_if;
    logic        ex_valid;
    logic        op_lb;
    logic        op_lbu;
    logic        op_lh;
    logic        op_lhu;
    logic        op_lw;
    logic        op_sb;
    logic        op_sh;
    logic        op_sw;
    logic [31:0] alu_q;
    logic [31:0] store_data;
    logic [4:0]  dest_reg;
    logic        stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        exc_adel;
    logic        exc_ades;
    logic        exc_buserr;
    logic [31:0] exc_addr;

    modport master (
        input  ex_valid, op_lb, op_lbu, op_lh, op_lhu, op_lw, op_sb, op_sh, op_sw,
        input  alu_q, store_data, dest_reg, dm_ack, dm_rdata,
        output stall, dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output wb_valid, wb_reg, wb_data, exc_adel, exc_ades, exc_buserr, exc_addr
    );

    modport slave (
        output ex_valid, op_lb, op_lbu, op_lh, op_lhu, op_lw, op_sb, op_sh, op_sw,
        output alu_q, store_data, dest_reg, dm_ack, dm_rdata,
        input  stall, dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  wb_valid, wb_reg, wb_data, exc_adel, exc_ades, exc_buserr, exc_addr
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: one outstanding req/ack data-memory access, lane steering,
// load extension, pipeline stall and address-error / bus-timeout exceptions.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input logic               clk,
    input logic               rst_n,
    mem_access_unit_if.master bus
);
    typedef enum logic {IDLE, ACCESS} state_t;

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [1:0]     SZ_B     = 2'd0;
    localparam logic [1:0]     SZ_H     = 2'd1;
    localparam logic [1:0]     SZ_W     = 2'd2;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;

    logic           is_mem, is_store, is_signed;
    logic [1:0]     size;
    logic           misaligned, go;
    logic           accept, ack_done, timeout_hit, stall_c;
    logic [3:0]     be_c;
    logic [31:0]    wdata_c;

    logic [31:0]    addr_reg, wdata_reg;
    logic [3:0]     be_reg;
    logic           we_reg, signed_reg;
    logic [1:0]     size_reg;
    logic [4:0]     dest_q_reg;
    logic           wb_valid_reg;
    logic [4:0]     wb_dest_reg;
    logic [31:0]    wb_data_reg;
    logic           exc_adel_reg, exc_ades_reg, exc_buserr_reg;
    logic [31:0]    exc_addr_reg;

    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;
    logic [31:0]    load_ext;

    // Multi-hot op vectors resolve by this if-chain order: lw > lh > lhu > lb > lbu > sw > sh > sb.
    always_comb begin
        is_mem    = 1'b1;
        is_store  = 1'b0;
        is_signed = 1'b0;
        size      = SZ_B;
        if (bus.op_lw) begin
            size = SZ_W;
        end else if (bus.op_lh) begin
            size = SZ_H;  is_signed = 1'b1;
        end else if (bus.op_lhu) begin
            size = SZ_H;
        end else if (bus.op_lb) begin
            is_signed = 1'b1;
        end else if (bus.op_lbu) begin
            size = SZ_B;
        end else if (bus.op_sw) begin
            size = SZ_W;  is_store = 1'b1;
        end else if (bus.op_sh) begin
            size = SZ_H;  is_store = 1'b1;
        end else if (bus.op_sb) begin
            is_store = 1'b1;
        end else begin
            is_mem = 1'b0;
        end
    end

    assign go         = bus.ex_valid & is_mem;
    assign misaligned = ((size == SZ_H) & bus.alu_q[0]) | ((size == SZ_W) & (|bus.alu_q[1:0]));

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign be_c[gi] = !is_store || (size == SZ_W)
                           || ((size == SZ_H) && (bus.alu_q[1] == 1'(gi / 2)))
                           || ((size == SZ_B) && (bus.alu_q[1:0] == 2'(gi)));
            assign wdata_c[8*gi +: 8] = (size == SZ_B) ? bus.store_data[7:0] :
                                        (size == SZ_H) ? bus.store_data[8*(gi%2) +: 8] :
                                                         bus.store_data[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        ld_byte = bus.dm_rdata[7:0];
        case (addr_reg[1:0])
            2'd1:    ld_byte = bus.dm_rdata[15:8];
            2'd2:    ld_byte = bus.dm_rdata[23:16];
            2'd3:    ld_byte = bus.dm_rdata[31:24];
            default: ld_byte = bus.dm_rdata[7:0];
        endcase
        ld_half = addr_reg[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];
        case (size_reg)
            SZ_B:    load_ext = {{24{signed_reg & ld_byte[7]}}, ld_byte};
            SZ_H:    load_ext = {{16{signed_reg & ld_half[15]}}, ld_half};
            default: load_ext = bus.dm_rdata;
        endcase
    end

    // In the final timeout cycle stall drops so the pipeline resumes on the same edge the bus error fires.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        stall_c     = 1'b0;
        accept      = 1'b0;
        ack_done    = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                if (go && !misaligned) begin
                    stall_c    = 1'b1;
                    accept     = 1'b1;
                    cnt_next   = '0;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (bus.dm_ack) begin
                    ack_done   = 1'b1;
                    state_next = IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else begin
                    stall_c  = 1'b1;
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg       <= '0;
            wdata_reg      <= '0;
            be_reg         <= '0;
            we_reg         <= 1'b0;
            signed_reg     <= 1'b0;
            size_reg       <= SZ_B;
            dest_q_reg     <= '0;
            wb_valid_reg   <= 1'b0;
            wb_dest_reg    <= '0;
            wb_data_reg    <= '0;
            exc_adel_reg   <= 1'b0;
            exc_ades_reg   <= 1'b0;
            exc_buserr_reg <= 1'b0;
            exc_addr_reg   <= '0;
        end else begin
            wb_valid_reg   <= 1'b0;
            exc_adel_reg   <= 1'b0;
            exc_ades_reg   <= 1'b0;
            exc_buserr_reg <= 1'b0;
            if (accept) begin
                addr_reg   <= bus.alu_q;
                wdata_reg  <= wdata_c;
                be_reg     <= be_c;
                we_reg     <= is_store;
                signed_reg <= is_signed;
                size_reg   <= size;
                dest_q_reg <= bus.dest_reg;
            end
            if (ack_done && !we_reg) begin
                wb_valid_reg <= 1'b1;
                wb_dest_reg  <= dest_q_reg;
                wb_data_reg  <= load_ext;
            end
            if (timeout_hit) begin
                exc_buserr_reg <= 1'b1;
                exc_addr_reg   <= addr_reg;
            end
            if ((state_reg == IDLE) && go && misaligned) begin
                exc_adel_reg <= !is_store;
                exc_ades_reg <= is_store;
                exc_addr_reg <= bus.alu_q;
            end
        end
    end

    // Reset must drop stall immediately even if EX is presenting an aligned op.
    assign bus.stall      = stall_c & rst_n;
    assign bus.dm_req     = (state_reg == ACCESS);
    assign bus.dm_we      = we_reg;
    assign bus.dm_addr    = {addr_reg[31:2], 2'b00};
    assign bus.dm_be      = be_reg;
    assign bus.dm_wdata   = wdata_reg;
    assign bus.wb_valid   = wb_valid_reg;
    assign bus.wb_reg     = wb_dest_reg;
    assign bus.wb_data    = wb_data_reg;
    assign bus.exc_adel   = exc_adel_reg;
    assign bus.exc_ades   = exc_ades_reg;
    assign bus.exc_buserr = exc_buserr_reg;
    assign bus.exc_addr   = exc_addr_reg;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected bus requests and
// results computed by a behavioural model; a negedge monitor pops and compares.
module tb_mem_access_unit;
    localparam int TIMEOUT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Event kinds: 0 writeback, 1 load address error, 2 store address error, 3 bus error.
    typedef struct {
        int          kind;
        logic [31:0] reg_no;
        logic [31:0] value;
    } ev_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        int          len;
    } req_t;

    ev_t  ev_q[$];
    req_t req_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Op index order doubles as priority order: 0 lw,1 lh,2 lhu,3 lb,4 lbu,5 sw,6 sh,7 sb.
    function automatic int op_bytes(input int op);
        if (op == 0 || op == 5) return 4;
        if (op == 1 || op == 2 || op == 6) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] ref_load(input int op, input logic [1:0] lo, input logic [31:0] rd);
        logic [31:0] v;
        case (op)
            0: v = rd;
            1, 2: begin
                v = (rd >> (16 * int'(lo[1]))) & 32'h0000_FFFF;
                if (op == 1 && v >= 32'h0000_8000) v = v | 32'hFFFF_0000;
            end
            default: begin
                v = (rd >> (8 * int'(lo))) & 32'h0000_00FF;
                if (op == 3 && v >= 32'h0000_0080) v = v | 32'hFFFF_FF00;
            end
        endcase
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input int op, input logic [1:0] lo);
        if (op < 6) return 4'hF;
        if (op == 6) return lo[1] ? 4'hC : 4'h3;
        return 4'(1 << int'(lo));
    endfunction

    function automatic logic [31:0] ref_wdata(input int op, input logic [31:0] sd);
        if (op == 6) return {16'h0, sd[15:0]} * 32'h0001_0001;
        if (op == 7) return {24'h0, sd[7:0]} * 32'h0101_0101;
        return sd;
    endfunction

    task automatic set_ops(input logic [7:0] bits);
        bus.op_lw  = bits[0];
        bus.op_lh  = bits[1];
        bus.op_lhu = bits[2];
        bus.op_lb  = bits[3];
        bus.op_lbu = bits[4];
        bus.op_sw  = bits[5];
        bus.op_sh  = bits[6];
        bus.op_sb  = bits[7];
    endtask

    // waits = ack-less ACCESS cycles before the ack; waits >= TIMEOUT means no ack at all.
    task automatic do_op(input logic exv, input logic [7:0] bits, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rd_reg,
                         input int waits, input logic [31:0] rdata);
        int   op;
        int   nwait;
        logic mis, aligned;
        req_t r;
        ev_t  e;
        op = -1;
        for (int i = 0; i < 8; i++) if (bits[i] && op < 0) op = i;
        if (!exv) op = -1;
        mis     = (op >= 0) && (a % op_bytes(op) != 0);
        aligned = (op >= 0) && !mis;
        nwait   = (waits >= TIMEOUT) ? TIMEOUT : waits;

        @(posedge clk); #1;
        bus.ex_valid   = exv;
        set_ops(bits);
        bus.alu_q      = a;
        bus.store_data = sd;
        bus.dest_reg   = rd_reg;
        bus.dm_ack     = 1'b0;
        if (mis) begin
            e.kind = (op >= 5) ? 2 : 1; e.reg_no = 0; e.value = a;
            ev_q.push_back(e);
        end else if (aligned) begin
            r.addr  = a & 32'hFFFF_FFFC;
            r.be    = ref_be(op, a[1:0]);
            r.wdata = ref_wdata(op, sd);
            r.we    = (op >= 5);
            r.len   = (waits >= TIMEOUT) ? TIMEOUT : waits + 1;
            req_q.push_back(r);
            if (waits >= TIMEOUT) begin
                e.kind = 3; e.reg_no = 0; e.value = a;
                ev_q.push_back(e);
            end else if (op < 5) begin
                e.kind = 0; e.reg_no = {27'h0, rd_reg}; e.value = ref_load(op, a[1:0], rdata);
                ev_q.push_back(e);
            end
        end
        @(negedge clk);
        check("stall_issue", {31'h0, bus.stall}, {31'h0, aligned});

        @(posedge clk); #1;
        bus.ex_valid   = 1'b0;
        set_ops(8'h00);
        bus.alu_q      = $urandom();
        bus.store_data = $urandom();
        bus.dest_reg   = 5'($urandom());
        bus.dm_rdata   = $urandom();
        if (aligned) begin
            for (int i = 0; i < nwait; i++) begin
                @(posedge clk); #1;
                bus.dm_rdata = $urandom();
            end
            if (waits < TIMEOUT) begin
                bus.dm_ack   = 1'b1;
                bus.dm_rdata = rdata;
                @(posedge clk); #1;
                bus.dm_ack   = 1'b0;
                bus.dm_rdata = $urandom();
            end
        end
    endtask

    // Monitor: checks every request cycle and every result pulse against the queues.
    req_t cur;
    int   req_len  = 0;
    logic req_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            req_len  = 0;
            req_prev = 1'b0;
        end else begin
            if (bus.dm_req) begin
                if (!req_prev) begin
                    if (req_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_req: got dm_req=1 addr 0x%08h, expected no request", bus.dm_addr);
                    end else begin
                        cur = req_q.pop_front();
                    end
                end
                req_len++;
                check("dm_addr", bus.dm_addr, cur.addr);
                check("dm_be", {28'h0, bus.dm_be}, {28'h0, cur.be});
                check("dm_we", {31'h0, bus.dm_we}, {31'h0, cur.we});
                if (cur.we) check("dm_wdata", bus.dm_wdata, cur.wdata);
                check("stall_access", {31'h0, bus.stall},
                      {31'h0, (!bus.dm_ack && req_len != TIMEOUT)});
            end else if (req_prev) begin
                check("req_len", 32'(req_len), 32'(cur.len));
                req_len = 0;
            end
            req_prev = bus.dm_req;

            if (bus.wb_valid || bus.exc_adel || bus.exc_ades || bus.exc_buserr) begin
                if (ev_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_pulse: got wb=%0b adel=%0b ades=%0b buserr=%0b, expected none",
                             bus.wb_valid, bus.exc_adel, bus.exc_ades, bus.exc_buserr);
                end else begin
                    ev_t e;
                    int  k;
                    e = ev_q.pop_front();
                    k = bus.wb_valid ? 0 : bus.exc_adel ? 1 : bus.exc_ades ? 2 : 3;
                    check("result_kind", 32'(k), 32'(e.kind));
                    if (e.kind == 0) begin
                        check("wb_reg", {27'h0, bus.wb_reg}, e.reg_no);
                        check("wb_data", bus.wb_data, e.value);
                    end else begin
                        check("exc_addr", bus.exc_addr, e.value);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.ex_valid   = 1'b0;
        set_ops(8'h00);
        bus.alu_q      = '0;
        bus.store_data = '0;
        bus.dest_reg   = '0;
        bus.dm_ack     = 1'b1;
        bus.dm_rdata   = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dm_req", {31'h0, bus.dm_req}, 32'h0);
        check("rst_stall", {31'h0, bus.stall}, 32'h0);
        check("rst_wb_valid", {31'h0, bus.wb_valid}, 32'h0);
        check("rst_exc", {29'h0, bus.exc_adel, bus.exc_ades, bus.exc_buserr}, 32'h0);
        check("rst_exc_addr", bus.exc_addr, 32'h0);
        check("rst_wb_data", bus.wb_data, 32'h0);
        rst_n = 1'b1;
        // Stale ack held across reset release must be ignored in IDLE.
        repeat (2) @(posedge clk);
        #1 bus.dm_ack = 1'b0;

        do_op(1'b1, 8'b0000_1000, 32'h0000_1003, 32'h0, 5'd7,  0, 32'h80FF_1234);
        do_op(1'b1, 8'b0001_0000, 32'h0000_1003, 32'h0, 5'd8,  0, 32'h80FF_1234);
        do_op(1'b1, 8'b0100_0000, 32'h0000_2002, 32'h0000_ABCD, 5'd0, 0, 32'h0);
        do_op(1'b1, 8'b0000_0001, 32'h0000_1001, 32'h0, 5'd3,  0, 32'h0);
        do_op(1'b1, 8'b0010_0000, 32'h0000_1002, 32'h1234_5678, 5'd0, 0, 32'h0);
        do_op(1'b1, 8'b0000_0010, 32'h0000_3002, 32'h0, 5'd9,  3, 32'h9ABC_1234);
        do_op(1'b1, 8'b0000_0001, 32'h0000_5004, 32'h0, 5'd10, TIMEOUT, 32'h0);
        do_op(1'b1, 8'b0000_0001, 32'h0000_5008, 32'h0, 5'd11, TIMEOUT - 1, 32'h1357_9BDF);
        do_op(1'b1, 8'b1000_0000, 32'h0000_600B, 32'h0000_00A5, 5'd0, 1, 32'h0);
        do_op(1'b1, 8'b0000_0000, 32'h0000_7000, 32'h0, 5'd1, 0, 32'h0);
        do_op(1'b0, 8'b0000_0001, 32'h0000_7000, 32'h0, 5'd1, 0, 32'h0);
        do_op(1'b1, 8'b1010_0110, 32'h0000_8002, 32'hFFFF_0000, 5'd12, 0, 32'hC001_7FFF);

        for (int n = 0; n < 80; n++) begin
            logic [7:0]  bits;
            logic [31:0] a;
            int          w;
            bits = 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) bits = 8'($urandom());
            a = $urandom();
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            w = $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) w = TIMEOUT + 4;
            if ($urandom_range(0, 15) == 0) w = TIMEOUT - 1;
            do_op($urandom_range(0, 15) != 0, bits, a, $urandom(), 5'($urandom()), w, $urandom());
        end

        // Reset in the middle of an access aborts it; a late ack afterwards is ignored.
        @(posedge clk); #1;
        bus.ex_valid = 1'b1;
        set_ops(8'b0000_0001);
        bus.alu_q    = 32'h0000_4000;
        bus.dest_reg = 5'd20;
        req_q.push_back('{addr: 32'h0000_4000, be: 4'hF, wdata: 32'h0, we: 1'b0, len: 0});
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
        set_ops(8'h00);
        @(posedge clk); #1;
        bus.ex_valid = 1'b1;
        set_ops(8'b0000_0001);
        rst_n = 1'b0;
        #1;
        check("abort_dm_req", {31'h0, bus.dm_req}, 32'h0);
        check("abort_stall", {31'h0, bus.stall}, 32'h0);
        req_q.delete();
        ev_q.delete();
        @(negedge clk);
        @(posedge clk); #1;
        rst_n        = 1'b1;
        bus.ex_valid = 1'b0;
        set_ops(8'h00);
        bus.dm_ack   = 1'b1;
        bus.dm_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        bus.dm_ack = 1'b0;
        @(negedge clk);
        check("late_ack_wb", {31'h0, bus.wb_valid}, 32'h0);
        check("late_ack_req", {31'h0, bus.dm_req}, 32'h0);

        repeat (4) @(posedge clk);
        #1;
        check("ev_q_empty", 32'(ev_q.size()), 32'h0);
        check("req_q_empty", 32'(req_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
